// File: rtl/wl_pkg.sv
// ----------------------------------------------------------------------------
// wl_pkg
// Shared definitions for the word-line burst decoder: command mode encodings,
// FSM state encodings and a small constant helper used for counter sizing.
// ----------------------------------------------------------------------------
package wl_pkg;

   // Command modes as presented on the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_SINGLE  = 2'b00,
      MODE_BURST   = 2'b01,
      MODE_BCAST   = 2'b10,
      MODE_ILLEGAL = 2'b11
   } mode_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Larger of two integers; used at elaboration time only.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : wl_pkg

// File: rtl/onehot_dec.sv
// ----------------------------------------------------------------------------
// onehot_dec
// Combinational binary-to-one-hot decoder.
//   bin_in     : row index
//   en         : when low the output is all zeros
//   onehot_out : 2**ADDR_W wide, bit bin_in set when enabled
// ----------------------------------------------------------------------------
module onehot_dec #(
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0]      bin_in,
   input  logic                   en,
   output logic [(2**ADDR_W)-1:0] onehot_out
);

   localparam int ROWS = 2**ADDR_W;

   // NOTE: every output of a combinational block gets a value on every path
   // (default first), otherwise synthesis infers a latch.
   always_comb begin
      onehot_out = '0;
      if (en) onehot_out = ROWS'(1) << bin_in;
   end

endmodule : onehot_dec

// File: rtl/wl_burst_decoder.sv
// ----------------------------------------------------------------------------
// wl_burst_decoder
// Word-line pulse sequencer. A command selects one row (SINGLE), a run of
// len+1 consecutive rows with wrap-around (BURST) or every row at once
// (BROADCAST). Each row is held for PULSE_CYC cycles; burst rows are separated
// by GAP_CYC all-zero cycles so two rows are never driven together.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_valid  : command request; start_ready high when it can be taken
//   mode/addr/len: command fields, captured on acceptance
//   abort        : cancel the active command (ignored when idle)
//   wl_out       : registered word-line drive
//   cur_addr     : row currently driven (holds its value when idle)
//   busy         : command in progress
//   done / err   : one-cycle completion pulse / illegal-mode flag with done
// ----------------------------------------------------------------------------
module wl_burst_decoder
   import wl_pkg::*;
#(
   parameter int ADDR_W    = 4,
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [1:0]             mode,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [ADDR_W-1:0]      len,
   input  logic                   abort,
   output logic [(2**ADDR_W)-1:0] wl_out,
   output logic [ADDR_W-1:0]      cur_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int ROWS  = 2**ADDR_W;
   localparam int CNT_W = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYC - 1);

   state_e            state;
   logic [CNT_W-1:0]  cnt;        // cycles spent in the current PULSE/GAP
   logic [ADDR_W:0]   rows_left;  // burst rows still to drive after this one
   logic [ADDR_W-1:0] dec_addr;
   logic [ROWS-1:0]   dec_out;

   // Whenever wl_out is loaded with a row it is either the incoming command
   // address (leaving IDLE) or the already-advanced cur_addr (leaving GAP).
   assign dec_addr = (state == ST_IDLE) ? addr : cur_addr;

   onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .bin_in     (dec_addr),
      .en         (1'b1),
      .onehot_out (dec_out)
   );

   assign start_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wl_out    <= '0;
         cur_addr  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         rows_left <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && state != ST_IDLE) begin
            state     <= ST_IDLE;
            wl_out    <= '0;
            cnt       <= '0;
            rows_left <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_valid) begin
                     cur_addr <= addr;
                     cnt      <= '0;
                     if (mode == MODE_ILLEGAL) begin
                        // Illegal mode completes immediately, never drives rows.
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        rows_left <= '0;
                     end else begin
                        state     <= ST_PULSE;
                        wl_out    <= (mode == MODE_BCAST) ? '1 : dec_out;
                        rows_left <= (mode == MODE_BURST) ? {1'b0, len} : '0;
                     end
                  end
               end
               ST_PULSE: begin
                  if (cnt == PULSE_END) begin
                     cnt    <= '0;
                     wl_out <= '0;
                     if (rows_left != '0) begin
                        state     <= ST_GAP;
                        rows_left <= rows_left - (ADDR_W + 1)'(1);
                        cur_addr  <= cur_addr + ADDR_W'(1);  // wraps modulo ROWS
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_GAP: begin
                  if (cnt == GAP_END) begin
                     cnt    <= '0;
                     state  <= ST_PULSE;
                     wl_out <= dec_out;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin  // ST_DONE
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule : wl_burst_decoder

// File: tb/tb_wl_burst_decoder.sv
// ----------------------------------------------------------------------------
// tb_wl_burst_decoder
// Self-checking bench for wl_burst_decoder (ADDR_W=4, PULSE_CYC=4, GAP_CYC=1).
// Expected per-cycle behaviour comes from a trace built directly from the
// command rules (rows, pulse length, gaps, done/idle cycles).
// ----------------------------------------------------------------------------
module tb_wl_burst_decoder;
   import wl_pkg::*;

   localparam int ADDR_W    = 4;
   localparam int ROWS      = 16;
   localparam int PULSE_CYC = 4;
   localparam int GAP_CYC   = 1;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [1:0]  mode;
   logic [3:0]  addr;
   logic [3:0]  len;
   logic        abort;
   logic [15:0] wl_out;
   logic [3:0]  cur_addr;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   wl_burst_decoder #(
      .ADDR_W(ADDR_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .mode        (mode),
      .addr        (addr),
      .len         (len),
      .abort       (abort),
      .wl_out      (wl_out),
      .cur_addr    (cur_addr),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One expected observation cycle.
   typedef struct {
      logic [15:0] wl;
      logic [3:0]  ca;
      logic        chk_ca;
      logic        done;
      logic        err;
      logic        busy;
      logic        ready;
   } exp_t;

   exp_t exp_q[$];

   // Directed command vectors with hand-derived key expectations.
   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  addr;
      logic [3:0]  len;
      logic [15:0] exp_first_wl;  // wl_out at T1
      int          exp_done_t;    // cycle index (T1 = 1) where done is seen
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] wl, input logic [3:0] ca, input logic chk_ca,
                       input logic d, input logic e, input logic b, input logic r);
      exp_t x;
      x.wl = wl; x.ca = ca; x.chk_ca = chk_ca;
      x.done = d; x.err = e; x.busy = b; x.ready = r;
      exp_q.push_back(x);
   endtask

   // Builds the cycle-by-cycle observation list starting at T1.
   task automatic build_trace(input logic [1:0] m, input logic [3:0] a, input logic [3:0] l);
      int nrows;
      int row;
      exp_q.delete();
      if (m == 2'b10) begin
         for (int c = 0; c < PULSE_CYC; c++) push(16'hFFFF, a, 1'b1, 0, 0, 1, 0);
      end else if (m != 2'b11) begin
         nrows = (m == 2'b01) ? int'(l) + 1 : 1;
         for (int r = 0; r < nrows; r++) begin
            row = (int'(a) + r) % ROWS;
            for (int c = 0; c < PULSE_CYC; c++)
               push(16'(1) << row, 4'(row), 1'b1, 0, 0, 1, 0);
            if (r < nrows - 1)
               for (int c = 0; c < GAP_CYC; c++) push(16'h0, 4'h0, 1'b0, 0, 0, 1, 0);
         end
      end
      push(16'h0, 4'h0, 1'b0, 1, (m == 2'b11), 1, 0);
      push(16'h0, 4'h0, 1'b0, 0, 0, 0, 1);
   endtask

   // Issues one command and compares every cycle until it is idle again.
   task automatic run_cmd(input logic [1:0] m, input logic [3:0] a, input logic [3:0] l,
                          output int done_t, output logic [15:0] first_wl, output logic err_seen);
      build_trace(m, a, l);
      done_t = 0; first_wl = 16'h0; err_seen = 1'b0;
      @(negedge clk);
      start_valid = 1'b1; mode = m; addr = a; len = l;
      @(negedge clk);
      start_valid = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k > 0) @(negedge clk);
         if (k == 0) first_wl = wl_out;
         if (done && done_t == 0) done_t = k + 1;
         if (err) err_seen = 1'b1;
         check("wl_out", 32'(wl_out), 32'(exp_q[k].wl));
         check("done", 32'(done), 32'(exp_q[k].done));
         check("err", 32'(err), 32'(exp_q[k].err));
         check("busy", 32'(busy), 32'(exp_q[k].busy));
         check("start_ready", 32'(start_ready), 32'(exp_q[k].ready));
         if (exp_q[k].chk_ca) check("cur_addr", 32'(cur_addr), 32'(exp_q[k].ca));
         if (m != 2'b10) check("at_most_one_row", 32'($countones(wl_out) <= 1), 32'd1);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!start_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(start_ready), 32'd1);
   endtask

   vec_t vecs[6];

   initial begin
      int          dt;
      logic [15:0] fw;
      logic        es;
      logic [1:0]  rm;

      vecs[0] = '{2'b00, 4'd5,  4'd0, 16'h0020, 5,  1'b0};
      vecs[1] = '{2'b01, 4'd14, 4'd2, 16'h4000, 15, 1'b0};
      vecs[2] = '{2'b10, 4'd0,  4'd0, 16'hFFFF, 5,  1'b0};
      vecs[3] = '{2'b11, 4'd3,  4'd0, 16'h0000, 1,  1'b1};
      vecs[4] = '{2'b01, 4'd15, 4'd0, 16'h8000, 5,  1'b0};
      vecs[5] = '{2'b00, 4'd0,  4'd9, 16'h0001, 5,  1'b0};

      rst_n = 1'b0; start_valid = 1'b0; mode = 2'b00; addr = 4'h0; len = 4'h0; abort = 1'b0;

      // Reset state.
      #1;
      check("rst_wl_out", 32'(wl_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_cur_addr", 32'(cur_addr), 32'h0);
      check("rst_start_ready", 32'(start_ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      foreach (vecs[i]) begin
         run_cmd(vecs[i].mode, vecs[i].addr, vecs[i].len, dt, fw, es);
         check($sformatf("vec%0d_first_wl", i), 32'(fw), 32'(vecs[i].exp_first_wl));
         check($sformatf("vec%0d_done_t", i), 32'(dt), 32'(vecs[i].exp_done_t));
         check($sformatf("vec%0d_err", i), 32'(es), 32'(vecs[i].exp_err));
      end

      // Abort during the second burst row's 2nd cycle (T7).
      @(negedge clk);
      start_valid = 1'b1; mode = MODE_BURST; addr = 4'd0; len = 4'd3;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_pre_wl", 32'(wl_out), 32'h0002);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_wl", 32'(wl_out), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_ready", 32'(start_ready), 32'h1);
      check("abort_busy", 32'(busy), 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("abort_quiet_done", 32'(done), 32'h0);
         check("abort_quiet_wl", 32'(wl_out), 32'h0);
      end

      // Abort together with start_valid in IDLE is still an accept.
      start_valid = 1'b1; abort = 1'b1; mode = MODE_SINGLE; addr = 4'd3; len = 4'd0;
      @(negedge clk);
      start_valid = 1'b0; abort = 1'b0;
      check("idle_abort_accept_wl", 32'(wl_out), 32'h0008);
      check("idle_abort_accept_busy", 32'(busy), 32'h1);
      wait_idle("idle_abort_finish");

      // Asynchronous reset in the middle of a pulse.
      @(negedge clk);
      start_valid = 1'b1; mode = MODE_SINGLE; addr = 4'd7;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_pre_wl", 32'(wl_out), 32'h0080);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_wl", 32'(wl_out), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_cur_addr", 32'(cur_addr), 32'h0);
      check("rst_mid_ready", 32'(start_ready), 32'h1);
      check("rst_mid_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("post_rst_idle_busy", 32'(busy), 32'h0);
         check("post_rst_idle_wl", 32'(wl_out), 32'h0);
      end

      // start_valid held while busy is accepted only once IDLE.
      start_valid = 1'b1; mode = MODE_BURST; addr = 4'd2; len = 4'd1;
      @(negedge clk);                       // T1
      mode = MODE_SINGLE; addr = 4'd9;      // held request for a new command
      check("held_t1_wl", 32'(wl_out), 32'h0004);
      for (int t = 2; t <= 9; t++) begin
         @(negedge clk);
         check("held_no_early_accept", 32'(wl_out == 16'h0200), 32'h0);
      end
      @(negedge clk);                       // T10
      check("held_done", 32'(done), 32'h1);
      @(negedge clk);                       // T11
      check("held_idle_ready", 32'(start_ready), 32'h1);
      @(negedge clk);                       // T12
      start_valid = 1'b0;
      check("held_accept_wl", 32'(wl_out), 32'h0200);
      wait_idle("held_finish");

      // Randomized commands against the trace model.
      for (int i = 0; i < 24; i++) begin
         rm = 2'($urandom_range(0, 3));
         run_cmd(rm, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dt, fw, es);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wl_burst_decoder
